// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with 4-word (128-bit) blocks.
// A hit returns its word in the same cycle. A miss latches the block address
// and waits in ALLOCATE until memory returns the whole block.
module icache #(
   parameter int unsigned INDEX_W = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          proc_read,
   input  logic          proc_write,
   input  logic [29:0]   proc_addr,
   input  logic [31:0]   proc_wdata,
   output logic          proc_stall,
   output logic [31:0]   proc_rdata,
   output logic          mem_read,
   output logic          mem_write,
   output logic [27:0]   mem_addr,
   output logic [127:0]  mem_wdata,
   input  logic [127:0]  mem_rdata,
   input  logic          mem_ready
);

   localparam int unsigned N_BLOCKS = 1 << INDEX_W;
   localparam int unsigned BADDR_W  = 28;
   localparam int unsigned TAG_W    = BADDR_W - INDEX_W;
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned BLOCK_W  = 128;

   typedef enum logic {
      S_COMPARE  = 1'b0,
      S_ALLOCATE = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [N_BLOCKS-1:0]  r_valid;
   logic [TAG_W-1:0]     r_tag  [N_BLOCKS];
   logic [BLOCK_W-1:0]   r_data [N_BLOCKS];
   logic [BADDR_W-1:0]   r_miss_addr;

   logic [INDEX_W-1:0]   w_index;
   logic [TAG_W-1:0]     w_tag;
   logic [1:0]           w_offset;
   logic                 w_hit;
   logic [WORD_W-1:0]    w_word;
   logic                 w_latch_miss;
   logic                 w_refill;
   logic [INDEX_W-1:0]   w_fill_index;
   logic [TAG_W-1:0]     w_fill_tag;
   logic                 w_unused;

   // Address split and lookup of the currently requested word
   assign w_offset     = proc_addr[1:0];
   assign w_index      = proc_addr[INDEX_W+1:2];
   assign w_tag        = proc_addr[29:INDEX_W+2];
   assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_word       = r_data[w_index][{w_offset, 5'b00000} +: WORD_W];
   assign w_fill_index = r_miss_addr[INDEX_W-1:0];
   assign w_fill_tag   = r_miss_addr[BADDR_W-1:INDEX_W];

   // Read-only cache: the write port toward memory is permanently idle
   assign mem_write = 1'b0;
   assign mem_wdata = '0;
   assign mem_addr  = r_miss_addr;

   // Processor write path is accepted but has no effect
   assign w_unused = ^{proc_write, proc_wdata};

   // Next-state, stall, read data and memory request decode
   always_comb begin
      w_next_state = r_state;
      w_latch_miss = 1'b0;
      w_refill     = 1'b0;
      proc_stall   = 1'b0;
      proc_rdata   = '0;
      mem_read     = 1'b0;
      case (r_state)
         S_COMPARE: begin
            if (proc_read) begin
               if (w_hit) begin
                  proc_rdata = w_word;
               end else begin
                  proc_stall   = 1'b1;
                  w_latch_miss = 1'b1;
                  w_next_state = S_ALLOCATE;
               end
            end
         end
         S_ALLOCATE: begin
            mem_read   = 1'b1;
            proc_stall = 1'b1;
            if (mem_ready) begin
               w_refill     = 1'b1;
               w_next_state = S_COMPARE;
            end
         end
         default: w_next_state = S_COMPARE;
      endcase
   end

   // State register; reset aborts any refill in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_COMPARE;
      else        r_state <= w_next_state;
   end

   // Valid bits and latched miss block address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= '0;
         r_miss_addr <= '0;
      end else begin
         if (w_latch_miss) r_miss_addr <= proc_addr[29:2];
         if (w_refill)     r_valid[w_fill_index] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid bits guard their use
   always_ff @(posedge clk) begin
      if (w_refill) begin
         r_tag[w_fill_index]  <= w_fill_tag;
         r_data[w_fill_index] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: expected words are queued when a read is issued
// and popped when the cache releases the stall.
module tb_icache;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          proc_read;
   logic          proc_write;
   logic [29:0]   proc_addr;
   logic [31:0]   proc_wdata;
   logic          proc_stall;
   logic [31:0]   proc_rdata;
   logic          mem_read;
   logic          mem_write;
   logic [27:0]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_rdata;
   logic          mem_ready;

   int            n_pass = 0;
   int            n_total = 0;
   logic [31:0]   exp_q[$];

   localparam logic [127:0] BLK_A = 128'h44443333_22221111_00000000_DEADBEEF;
   localparam logic [127:0] BLK_B = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
   localparam logic [127:0] BLK_C = 128'hC0C0C0C3_C0C0C0C2_C0C0C0C1_C0C0C0C0;
   localparam logic [127:0] BLK_D = 128'hD00DD003_D00DD002_D00DD001_D00DD000;

   icache #(.INDEX_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_stall (proc_stall),
      .proc_rdata (proc_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] w);
      return blk[32*w +: 32];
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Pop the oldest expected word and compare it against proc_rdata
   task automatic chk_pop(input string tag);
      logic [31:0] exp_w;
      if (exp_q.size() == 0) begin
         n_total++;
         $error("FAIL %s observed=scoreboard-empty expected=entry", tag);
      end else begin
         exp_w = exp_q.pop_front();
         chk(tag, 128'(proc_rdata), 128'(exp_w));
      end
   endtask

   // Issue a fetch; on a miss serve the refill after lat ALLOCATE cycles
   task automatic do_read(input logic [29:0] addr, input bit miss,
                          input logic [127:0] blk, input int lat, input bit toggle);
      exp_q.push_back(word_of(blk, addr[1:0]));
      @(posedge clk); #1;
      proc_read = 1'b1;
      proc_write = 1'b0;
      proc_addr = addr;
      #1;
      if (!miss) begin
         chk("hit_stall", 128'(proc_stall), 128'(1'b0));
         chk("hit_memrd", 128'(mem_read), 128'(1'b0));
         chk_pop("hit_data");
      end else begin
         chk("miss_stall", 128'(proc_stall), 128'(1'b1));
         for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (toggle) proc_addr = ~addr;
            if (k == lat) begin
               mem_ready = 1'b1;
               mem_rdata = blk;
               proc_addr = addr;
            end
            #1;
            chk("alloc_memrd", 128'(mem_read), 128'(1'b1));
            chk("alloc_addr", 128'(mem_addr), 128'(addr[29:2]));
            chk("alloc_stall", 128'(proc_stall), 128'(1'b1));
         end
         @(posedge clk); #1;
         mem_ready = 1'b0;
         mem_rdata = '0;
         #1;
         chk("refill_stall", 128'(proc_stall), 128'(1'b0));
         chk("refill_memrd", 128'(mem_read), 128'(1'b0));
         chk_pop("refill_data");
      end
   endtask

   initial begin
      rst_n = 1'b0;
      proc_read = 1'b0;
      proc_write = 1'b0;
      proc_addr = '0;
      proc_wdata = '0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      #1;
      chk("rst_stall", 128'(proc_stall), 128'(1'b0));
      chk("rst_memrd", 128'(mem_read), 128'(1'b0));
      chk("rst_memwr", 128'(mem_write), 128'(1'b0));
      chk("rst_memaddr", 128'(mem_addr), 128'(0));
      chk("rst_rdata", 128'(proc_rdata), 128'(0));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      // Cold miss, then hits to the rest of the block
      do_read(30'h0000_0004, 1'b1, BLK_A, 1, 1'b0);
      do_read(30'h0000_0007, 1'b0, BLK_A, 0, 1'b0);
      do_read(30'h0000_0005, 1'b0, BLK_A, 0, 1'b0);
      do_read(30'h0000_0006, 1'b0, BLK_A, 0, 1'b0);

      // Conflict on index 1 evicts tag 0; the original line misses again
      do_read(30'h0000_0024, 1'b1, BLK_B, 3, 1'b0);
      do_read(30'h0000_0026, 1'b0, BLK_B, 0, 1'b0);
      do_read(30'h0000_0004, 1'b1, BLK_A, 2, 1'b0);

      // mem_ready while idle must not write the array
      @(posedge clk); #1;
      proc_read = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = BLK_D;
      #1;
      chk("idle_stall", 128'(proc_stall), 128'(1'b0));
      chk("idle_memrd", 128'(mem_read), 128'(1'b0));
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      do_read(30'h0000_0005, 1'b0, BLK_A, 0, 1'b0);

      // Ten-cycle memory with proc_addr wandering during the refill
      do_read(30'h0000_0010, 1'b1, BLK_C, 10, 1'b1);
      do_read(30'h0000_0013, 1'b0, BLK_C, 0, 1'b0);
      do_read(30'h0000_0007, 1'b0, BLK_A, 0, 1'b0);

      // Reset in the middle of a refill, then a stale mem_ready
      @(posedge clk); #1;
      proc_read = 1'b1;
      proc_addr = 30'h0000_0040;
      #1;
      chk("abort_miss", 128'(proc_stall), 128'(1'b1));
      @(posedge clk); #2;
      chk("abort_memrd_pre", 128'(mem_read), 128'(1'b1));
      chk("abort_addr_pre", 128'(mem_addr), 128'(28'h000_0010));
      @(posedge clk); #3;
      proc_read = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_memrd", 128'(mem_read), 128'(1'b0));
      chk("abort_stall", 128'(proc_stall), 128'(1'b0));
      chk("abort_addr", 128'(mem_addr), 128'(0));
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b1;
      mem_rdata = BLK_D;
      #1;
      chk("stale_memrd", 128'(mem_read), 128'(1'b0));
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      do_read(30'h0000_0040, 1'b1, BLK_D, 2, 1'b0);
      do_read(30'h0000_0004, 1'b1, BLK_A, 1, 1'b0);

      // Writes are ignored entirely
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         proc_read = 1'b0;
         proc_write = 1'b1;
         proc_addr = (i == 0) ? 30'h0000_0040 : 30'($urandom);
         proc_wdata = $urandom;
         #1;
         chk("wr_memwr", 128'(mem_write), 128'(1'b0));
         chk("wr_memrd", 128'(mem_read), 128'(1'b0));
         chk("wr_stall", 128'(proc_stall), 128'(1'b0));
      end
      do_read(30'h0000_0043, 1'b0, BLK_D, 0, 1'b0);
      do_read(30'h0000_0006, 1'b0, BLK_A, 0, 1'b0);

      chk("sb_drained", 128'(exp_q.size()), 128'(0));
      @(posedge clk); #1;
      proc_read = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
